// File: rtl/nroot_if.sv
// Start/busy request bus for the integer root unit: operand and mode in,
// completion strobe with root and remainder out.
interface nroot_if #(
  parameter int WIDTH = 8
);
  localparam int YW = (WIDTH + 1) / 2;

  logic             start_i;
  logic             mode_i;
  logic [WIDTH-1:0] x_bi;
  logic             busy_o;
  logic             valid_o;
  logic [YW-1:0]    y_bo;
  logic [WIDTH-1:0] rem_bo;

  modport master (
    output start_i, mode_i, x_bi,
    input  busy_o, valid_o, y_bo, rem_bo
  );

  modport slave (
    input  start_i, mode_i, x_bi,
    output busy_o, valid_o, y_bo, rem_bo
  );
endinterface

// File: rtl/nroot_seq.sv
// Sequential integer square/cube root, digit-by-digit with a shift-add multiplier.
// Define NROOT_REM_EN to register and expose the remainder on rem_bo.
module nroot_seq #(
  parameter int WIDTH = 8,
  parameter int YW    = (WIDTH + 1) / 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  nroot_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start_i
  // SHIFT | open a new root digit: y <<= 1
  // MUL   | cube only: p = y*(y+1), one multiplier bit per cycle
  // BUILD | form the trial subtrahend b
  // CMP   | subtract b when it fits and set the digit
  // DONE  | publish y_bo / rem_bo and strobe valid_o
  typedef enum logic [2:0] {IDLE, SHIFT, MUL, BUILD, CMP, DONE} state_t;

  localparam int PW = 2 * WIDTH;
  localparam int BW = 2 * WIDTH + 2;
  localparam int SW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int N2 = (WIDTH + 1) / 2;
  localparam int N3 = (WIDTH + 2) / 3;
  localparam int S2 = 2 * (N2 - 1);
  localparam int S3 = 3 * (N3 - 1);

  state_t           state;
  logic [WIDTH-1:0] xr;
  logic             m;
  logic [YW-1:0]    y;
  logic [SW-1:0]    s;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    p;
  logic [BW-1:0]    b;
  logic             valid_q;
  logic [YW-1:0]    y_q;

  logic [YW-1:0]    y_sh;
  logic [BW-1:0]    p3;
  logic [BW-1:0]    b_base;
  logic [BW-1:0]    b_next;
  logic             fits;
  logic [SW-1:0]    k;

  assign y_sh   = y << 1;
  assign p3     = {2'b00, p} + {1'b0, p, 1'b0};
  assign b_base = m ? p3 : BW'({y, 1'b0});
  assign b_next = (b_base + BW'(1)) << s;
  assign fits   = {{(BW-WIDTH){1'b0}}, xr} >= b;
  assign k      = m ? SW'(3) : SW'(2);

  assign bus.busy_o  = (bus.start_i && (state == IDLE)) || (state != IDLE);
  assign bus.valid_o = valid_q;
  assign bus.y_bo    = y_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      xr      <= '0;
      m       <= 1'b0;
      y       <= '0;
      s       <= '0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      p       <= '0;
      b       <= '0;
      valid_q <= 1'b0;
      y_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            xr    <= bus.x_bi;
            m     <= bus.mode_i;
            y     <= '0;
            s     <= bus.mode_i ? SW'(S3) : SW'(S2);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          y      <= y_sh;
          mcand  <= PW'(y_sh);
          mplier <= WIDTH'(y_sh) + WIDTH'(1);
          p      <= '0;
          cnt    <= CW'(WIDTH - 1);
          state  <= m ? MUL : BUILD;
        end
        MUL: begin
          if (mplier[0]) p <= p + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) state <= BUILD;
          else           cnt   <= cnt - CW'(1);
        end
        BUILD: begin
          b     <= b_next;
          state <= CMP;
        end
        CMP: begin
          // b never exceeds xr when it fits, so the low WIDTH bits are exact
          if (fits) begin
            xr <= xr - b[WIDTH-1:0];
            y  <= y + YW'(1);
          end
          if (s == '0) begin
            state <= DONE;
          end else begin
            s     <= s - k;
            state <= SHIFT;
          end
        end
        DONE: begin
          y_q     <= y;
          valid_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NROOT_REM_EN
  logic [WIDTH-1:0] rem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)              rem_q <= '0;
    else if (state == DONE) rem_q <= xr;
  end

  assign bus.rem_bo = rem_q;
`else
  assign bus.rem_bo = '0;
`endif
endmodule

// File: tb/tb_nroot_seq.sv
// Self-checking bench for nroot_seq at WIDTH=8 and WIDTH=16 with a result scoreboard.
module tb_nroot_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst16;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nroot_if #(.WIDTH(8))  b8();
  nroot_if #(.WIDTH(16)) b16();

  nroot_seq #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst8),  .bus(b8));
  nroot_seq #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_i(rst16), .bus(b16));

  typedef struct {
    int y;
    int rem;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t_start = 0;

  function automatic longint pw(longint v, int k);
    return (k == 2) ? v * v : v * v * v;
  endfunction

  function automatic exp_t model(int w, bit md, int x);
    exp_t e;
    int k = md ? 3 : 2;
    int n = (w + k - 1) / k;
    longint y = 0;
    while (pw(y + 1, k) <= longint'(x)) y++;
    e.y = int'(y);
`ifdef NROOT_REM_EN
    e.rem = x - int'(pw(y, k));
`else
    e.rem = 0;
`endif
    e.lat = md ? n * (w + 3) + 1 : 3 * n + 1;
    return e;
  endfunction

  task automatic drive(bit w16, bit st, bit md, int x);
    if (w16) begin
      b16.start_i = st; b16.mode_i = md; b16.x_bi = 16'(x);
    end else begin
      b8.start_i = st;  b8.mode_i = md;  b8.x_bi = 8'(x);
    end
  endtask

  function automatic logic get_valid(bit w16);
    return w16 ? b16.valid_o : b8.valid_o;
  endfunction
  function automatic logic get_busy(bit w16);
    return w16 ? b16.busy_o : b8.busy_o;
  endfunction
  function automatic int get_y(bit w16);
    return w16 ? int'(b16.y_bo) : int'(b8.y_bo);
  endfunction
  function automatic int get_rem(bit w16);
    return w16 ? int'(b16.rem_bo) : int'(b8.rem_bo);
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic start_req(bit w16, bit md, int x);
    sb.push_back(model(w16 ? 16 : 8, md, x));
    drive(w16, 1'b1, md, x);
    #1;
    n_cmp++;
    if (get_busy(w16) !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_on_start x=%0d: got %b want 1", x, get_busy(w16));
    end
    @(posedge clk);
    @(negedge clk);
    t_start = cyc;
    drive(w16, 1'b0, !md, ~x);
    n_cmp++;
    if (get_busy(w16) !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_running x=%0d: got %b want 1", x, get_busy(w16));
    end
  endtask

  task automatic wait_req(bit w16, string tag);
    exp_t e;
    bit   got = 1'b0;
    int   lat;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (get_valid(w16) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s timeout: no valid_o within 200 cycles", tag);
      return;
    end
    lat = cyc - t_start;
    n_cmp++;
    if (get_y(w16) !== e.y) begin
      n_bad++;
      $display("FAIL %s y_bo: got %0d want %0d", tag, get_y(w16), e.y);
    end
    n_cmp++;
    if (get_rem(w16) !== e.rem) begin
      n_bad++;
      $display("FAIL %s rem_bo: got %0d want %0d", tag, get_rem(w16), e.rem);
    end
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat);
    end
    n_cmp++;
    if (get_busy(w16) !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_after_done: got %b want 0", tag, get_busy(w16));
    end
  endtask

  task automatic check_quiet(bit w16, int cycles, string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (get_valid(w16) === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL %s stray_valid: got %0d strobes want 0", tag, seen);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    rst8 = 1'b1; rst16 = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_cmp++;
      if (get_valid(w[0]) !== 1'b0) begin n_bad++; $display("FAIL reset_valid w16=%0d: got %b want 0", w, get_valid(w[0])); end
      n_cmp++;
      if (get_busy(w[0]) !== 1'b0) begin n_bad++; $display("FAIL reset_busy w16=%0d: got %b want 0", w, get_busy(w[0])); end
      n_cmp++;
      if (get_y(w[0]) !== 0) begin n_bad++; $display("FAIL reset_y w16=%0d: got %0d want 0", w, get_y(w[0])); end
      n_cmp++;
      if (get_rem(w[0]) !== 0) begin n_bad++; $display("FAIL reset_rem w16=%0d: got %0d want 0", w, get_rem(w[0])); end
    end
    rst8 = 1'b0; rst16 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_square8();
    start_req(1'b0, 1'b0, 16);
    wait_req(1'b0, "sq8_16");
    start_req(1'b0, 1'b0, 255);
    wait_req(1'b0, "sq8_255");
    @(negedge clk);
    n_cmp++;
    if (b8.valid_o !== 1'b0) begin n_bad++; $display("FAIL strobe_width: got %b want 0", b8.valid_o); end
  endtask

  task automatic test_cube8();
    start_req(1'b0, 1'b1, 27);
    wait_req(1'b0, "cb8_27");
    start_req(1'b0, 1'b1, 255);
    wait_req(1'b0, "cb8_255");
    start_req(1'b0, 1'b1, 0);
    wait_req(1'b0, "cb8_0");
  endtask

  task automatic test_width16();
    start_req(1'b1, 1'b0, 65535);
    wait_req(1'b1, "sq16_65535");
    start_req(1'b1, 1'b1, 65535);
    wait_req(1'b1, "cb16_65535");
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    start_req(1'b0, 1'b1, 200);
    while (cyc - t_start < 11) begin
      if ((cyc - t_start) >= 4 && (cyc - t_start) <= 9) drive(1'b0, 1'b1, 1'b0, 9);
      else                                              drive(1'b0, 1'b0, 1'b0, 9);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 9);
    wait_req(1'b0, "ignore_start");
    check_quiet(1'b0, 40, "ignore_start");
  endtask

  task automatic test_reset_mid();
    start_req(1'b0, 1'b0, 100);
    while (cyc - t_start < 5) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    void'(sb.pop_back());
    n_cmp++;
    if (b8.busy_o !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", b8.busy_o); end
    n_cmp++;
    if (b8.y_bo !== 8'd0) begin n_bad++; $display("FAIL midreset_y: got %0d want 0", b8.y_bo); end
    n_cmp++;
    if (b8.rem_bo !== 8'd0) begin n_bad++; $display("FAIL midreset_rem: got %0d want 0", b8.rem_bo); end
    n_cmp++;
    if (b8.valid_o !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", b8.valid_o); end
    rst8 = 1'b0;
    check_quiet(1'b0, 40, "midreset");
    start_req(1'b0, 1'b0, 100);
    wait_req(1'b0, "after_reset_100");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int md = 0; md < 2; md++) begin
      for (int x = 0; x < 256; x++) begin
        start_req(1'b0, md[0], x);
        wait_req(1'b0, md ? "exh_cube" : "exh_sq");
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_square8();
    test_cube8();
    test_width16();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
